magic_device_arbiter: RTL and testbench

Shares the single read port of the magic device (12-bit select, ready/valid, 64-bit data) among `NUM_REQ` requesters, e.g. the core's CSR-side probe, the debug reader and the testbench harness. It performs round-robin arbitration, keeps exactly one transaction outstanding at the device, and returns each response to the requester that issued it. A per-transaction timeout converts a hung device into an error response, so no requester stalls forever.

---
 rtl/magic_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 39 +++
 rtl/magic_device_arbiter.sv | 144 ++++++++++++++
 tb/tb_magic_device_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/magic_arb_pkg.sv
// Shared types and constants for the magic device read-port arbiter.
package magic_arb_pkg;

    // Arbiter states: waiting for a requester, waiting on the device, presenting a response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Data handed back when the device never answers
    localparam logic [63:0] ERR_DATA_DEFAULT = 64'hDEAD_BEEF_DEAD_BEEF;

    // Width of the per-transaction timeout counter; covers TIMEOUT up to 255
    localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the requesters starting at ptr and grant the first one that is asking
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/magic_device_arbiter.sv
// Round-robin arbiter sharing the magic device read port, one transaction in flight,
// with a timeout that turns a hung device into an error response.
module magic_device_arbiter
    import magic_arb_pkg::*;
#(
    parameter int                NUM_REQ  = 4,
    parameter int                SEL_W    = 12,
    parameter int                DATA_W   = 64,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*SEL_W-1:0] req_select,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_err,
    output logic [SEL_W-1:0]         dev_read_select,
    output logic                     dev_read_ready,
    input  logic                     dev_read_valid,
    input  logic [DATA_W-1:0]        dev_read_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rrPtr_q, rrPtr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [TMO_CNT_W-1:0]   tmoCnt_q, tmoCnt_d;
    logic [SEL_W-1:0]       select_q, select_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   err_q, err_d;

    logic [NUM_REQ-1:0]     pickGnt;
    logic [IDX_W-1:0]       pickIdx;
    logic [SEL_W-1:0]       pickSel;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req (req_valid),
        .ptr (rrPtr_q),
        .gnt (pickGnt),
        .idx (pickIdx)
    );

    // Pull out the select of whichever requester the picker chose
    always_comb begin
        pickSel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickGnt[i]) begin
                pickSel = req_select[i*SEL_W +: SEL_W];
            end
        end
    end

    // Next-state logic: accept in IDLE, wait for data or timeout, hold response until taken
    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        owner_d   = owner_q;
        tmoCnt_d  = tmoCnt_q;
        select_d  = select_q;
        data_d    = data_q;
        err_d     = err_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = pickGnt;
                if (|pickGnt) begin
                    owner_d  = pickIdx;
                    select_d = pickSel;
                    tmoCnt_d = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                tmoCnt_d = tmoCnt_q + TMO_CNT_W'(1);
                if (dev_read_valid) begin
                    data_d  = dev_read_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmoCnt_q == TMO_LAST) begin
                    data_d  = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready[owner_q]) begin
                    state_d = IDLE;
                    if (owner_q == IDX_W'(NUM_REQ - 1)) begin
                        rrPtr_d = '0;
                    end else begin
                        rrPtr_d = owner_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so a reset can abort a WAIT
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rrPtr_q  <= '0;
            owner_q  <= '0;
            tmoCnt_q <= '0;
            select_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rrPtr_q  <= rrPtr_d;
            owner_q  <= owner_d;
            tmoCnt_q <= tmoCnt_d;
            select_q <= select_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Steer the response valid to the owner only while a response is being presented
    always_comb begin
        resp_valid = '0;
        if (state_q == RESP) begin
            resp_valid[owner_q] = 1'b1;
        end
    end

    assign resp_data       = data_q;
    assign resp_err        = err_q;
    assign dev_read_select = select_q;
    assign dev_read_ready  = (state_q == WAIT);

endmodule

// File: tb/tb_magic_device_arbiter.sv
// Self-checking bench for magic_device_arbiter: table of single transactions plus
// hand-written late-response and reset-during-WAIT sequences.
module tb_magic_device_arbiter;

    localparam int          NUM_REQ  = 4;
    localparam int          SEL_W    = 12;
    localparam int          DATA_W   = 64;
    localparam int          TIMEOUT  = 8;
    localparam logic [63:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    logic                     clock;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*SEL_W-1:0] req_select;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [DATA_W-1:0]        resp_data;
    logic                     resp_err;
    logic [SEL_W-1:0]         dev_read_select;
    logic                     dev_read_ready;
    logic                     dev_read_valid;
    logic [DATA_W-1:0]        dev_read_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NUM_REQ-1:0] mask;
        int                 expIdx;
        int                 delay;
        logic [63:0]        data;
        int                 hold;
    } vec_t;

    vec_t vecs[12];

    magic_device_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .SEL_W    (SEL_W),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_select      (req_select),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .dev_read_select (dev_read_select),
        .dev_read_ready  (dev_read_ready),
        .dev_read_valid  (dev_read_valid),
        .dev_read_data   (dev_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete transaction; entered and left at #1 after a rising edge in IDLE
    task automatic applyStimulus(input vec_t v);
        logic [NUM_REQ-1:0] oh;
        logic [63:0]        expData;
        logic               expErr;
        int                 expCycle;
        int                 respCycle;
        oh        = NUM_REQ'(1) << v.expIdx;
        expErr    = (v.delay == 0);
        expData   = expErr ? ERR_DATA : v.data;
        expCycle  = expErr ? TIMEOUT + 1 : v.delay + 1;
        respCycle = -1;

        req_valid = v.mask;
        @(negedge clock);
        checkOutput("grant", 64'(req_ready), 64'(oh));
        checkOutput("dev_ready_c0", 64'(dev_read_ready), 64'd0);
        @(posedge clock); #1;
        req_valid = '0;

        for (int cyc = 1; cyc <= TIMEOUT + 4; cyc++) begin
            dev_read_valid = (cyc == v.delay);
            dev_read_data  = (cyc == v.delay) ? v.data : 64'hBAD0_BAD0_BAD0_BAD0;
            @(negedge clock);
            if (cyc == 1) begin
                checkOutput("dev_ready_c1", 64'(dev_read_ready), 64'd1);
                checkOutput("dev_select", 64'(dev_read_select), 64'(12'h121 + v.expIdx));
            end
            if (resp_valid != '0) begin
                respCycle = cyc;
                break;
            end
            @(posedge clock); #1;
        end
        dev_read_valid = 1'b0;

        checkOutput("resp_cycle", 64'(respCycle), 64'(expCycle));
        checkOutput("resp_valid", 64'(resp_valid), 64'(oh));
        checkOutput("resp_data", resp_data, expData);
        checkOutput("resp_err", 64'(resp_err), 64'(expErr));
        checkOutput("dev_ready_resp", 64'(dev_read_ready), 64'd0);

        for (int h = 0; h < v.hold; h++) begin
            @(posedge clock); #1;
            req_valid      = '1;
            resp_ready     = ~oh;
            dev_read_valid = 1'b1;
            dev_read_data  = 64'h0123_4567_89AB_CDEF;
            @(negedge clock);
            checkOutput("hold_valid", 64'(resp_valid), 64'(oh));
            checkOutput("hold_data", resp_data, expData);
            checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
            checkOutput("hold_dev_ready", 64'(dev_read_ready), 64'd0);
        end

        @(posedge clock); #1;
        req_valid      = '0;
        dev_read_valid = 1'b0;
        resp_ready     = oh;
        @(negedge clock);
        checkOutput("resp_before_hs", 64'(resp_valid), 64'(oh));
        @(posedge clock); #1;
        resp_ready = '0;
        @(negedge clock);
        checkOutput("resp_after_hs", 64'(resp_valid), 64'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        vec_t lateVec;
        vec_t postVec;

        reset_n        = 1'b0;
        req_valid      = '0;
        resp_ready     = '0;
        dev_read_valid = 1'b0;
        dev_read_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_select[i*SEL_W +: SEL_W] = SEL_W'(12'h121 + i);
        end

        // contention: every requester asking, grants rotate 0,1,2,3,0
        vecs[0]  = '{4'hF, 0, 1, 64'h1000, 0};
        vecs[1]  = '{4'hF, 1, 2, 64'h1001, 0};
        vecs[2]  = '{4'hF, 2, 1, 64'h1002, 0};
        vecs[3]  = '{4'hF, 3, 3, 64'h1003, 0};
        vecs[4]  = '{4'hF, 0, 1, 64'h1004, 0};
        // single request from requester 2 (select 0x123), answer 3 cycles after ready rises
        vecs[5]  = '{4'h4, 2, 4, 64'hA5A5, 0};
        vecs[6]  = '{4'h9, 3, 1, 64'h2222, 0};
        vecs[7]  = '{4'h6, 1, 2, 64'h3333, 0};
        // timeout, then valid on the exact timeout cycle
        vecs[8]  = '{4'h3, 0, 0, 64'h0, 0};
        vecs[9]  = '{4'h1, 0, TIMEOUT, 64'h5A5A_5A5A_1234_5678, 0};
        vecs[10] = '{4'hC, 2, 5, 64'h4444, 0};
        // backpressure for 10 cycles
        vecs[11] = '{4'h2, 1, 1, 64'h7777_6666, 10};

        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("reset_outputs",
                    64'({req_ready, resp_valid, dev_read_ready, dev_read_select, resp_err}), 64'd0);
        checkOutput("reset_data", resp_data, 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int n = 0; n < 12; n++) begin
            applyStimulus(vecs[n]);
        end

        // timeout followed by late device responses that must be dropped
        lateVec = '{4'h1, 0, 0, 64'h0, 0};
        applyStimulus(lateVec);
        for (int c = 0; c < 3; c++) begin
            dev_read_valid = 1'b1;
            dev_read_data  = 64'hFEED_FACE_0000_0001;
            @(negedge clock);
            checkOutput("late_resp_valid", 64'(resp_valid), 64'd0);
            checkOutput("late_dev_ready", 64'(dev_read_ready), 64'd0);
            @(posedge clock); #1;
        end
        dev_read_valid = 1'b0;

        // reset asserted in the middle of WAIT
        req_valid = 4'h4;
        @(negedge clock);
        checkOutput("mid_grant", 64'(req_ready), 64'h4);
        @(posedge clock); #1;
        req_valid = '0;
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_reset_outputs",
                    64'({req_ready, resp_valid, dev_read_ready, dev_read_select, resp_err}), 64'd0);
        checkOutput("mid_reset_data", resp_data, 64'd0);
        @(posedge clock); #1;
        reset_n        = 1'b1;
        dev_read_valid = 1'b1;
        dev_read_data  = 64'hFEED_FACE_0000_0002;
        @(negedge clock);
        checkOutput("stale_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("stale_dev_ready", 64'(dev_read_ready), 64'd0);
        @(posedge clock); #1;
        dev_read_valid = 1'b0;
        postVec = '{4'hF, 0, 2, 64'h9999, 0};
        applyStimulus(postVec);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
